// File: rtl/button_irq_service_ctrl_if.sv
// button_irq_service_ctrl_if: Avalon-MM bus between the service controller and the button PIO
interface button_irq_service_ctrl_if;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic        irq;
  modport master (output address, chipselect, write_n, writedata, input readdata, irq);
  modport slave (input address, chipselect, write_n, writedata, output readdata, irq);
endinterface

// File: rtl/button_irq_service_ctrl.sv
// button_irq_service_ctrl: hardware service of button PIO irqs into an event FIFO (BUTTON_IRQ_SERVICE_CTRL_TIMESTAMP_EN adds evt_ts)
module button_irq_service_ctrl #(
  parameter int NUM_BTN = 2,
  parameter int FIFO_DEPTH = 4,
  parameter int HOLDOFF_CYCLES = 500000,
  parameter logic [NUM_BTN-1:0] MASK_INIT = {NUM_BTN{1'b1}},
  parameter int TS_W = 16
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 enable,
  button_irq_service_ctrl_if.master pio,
  output logic                 evt_valid,
  input  logic                 evt_ready,
  output logic [NUM_BTN-1:0]   evt_edges,
  output logic [NUM_BTN-1:0]   evt_level,
`ifdef BUTTON_IRQ_SERVICE_CTRL_TIMESTAMP_EN
  output logic [TS_W-1:0]      evt_ts,
`endif
  output logic                 overflow,
  output logic                 busy
);
  typedef enum logic [2:0] {INIT, IDLE, RD_EC, CAP_EC, CLR, PUSH, HOLD} state_t;
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int HW = HOLDOFF_CYCLES > 1 ? $clog2(HOLDOFF_CYCLES) : 1;
`ifdef BUTTON_IRQ_SERVICE_CTRL_TIMESTAMP_EN
  localparam int EW = 2*NUM_BTN + TS_W;
`else
  localparam int EW = 2*NUM_BTN + 0*TS_W;
`endif
  state_t state_q, state_d;
  logic [NUM_BTN-1:0] edges_q, edges_d, level_q, level_d;
  logic [HW-1:0] hold_q, hold_d;
  logic [1:0] addr_q, addr_d;
  logic cs_q, cs_d, wn_q, wn_d, ovf_q, ovf_d, push, pop, full;
  logic [31:0] wd_q, wd_d;
  logic [AW-1:0] rp_q, rp_d, wp_q, wp_d;
  logic [AW:0] cnt_q, cnt_d;
  logic [EW-1:0] mem_q [FIFO_DEPTH];
  logic [EW-1:0] head, push_data;
  logic unused_rd;
`ifdef BUTTON_IRQ_SERVICE_CTRL_TIMESTAMP_EN
  logic [TS_W-1:0] ts_q, ts_d, tsc_q, tsc_d;
  assign push_data = {tsc_q, edges_q, level_q};
  assign evt_ts = evt_valid ? head[EW-1:2*NUM_BTN] : '0;
`else
  assign push_data = {edges_q, level_q};
`endif
  assign unused_rd = ^pio.readdata;
  assign head = mem_q[rp_q];
  assign evt_valid = cnt_q != '0;
  assign evt_edges = evt_valid ? head[2*NUM_BTN-1:NUM_BTN] : '0;
  assign evt_level = evt_valid ? head[NUM_BTN-1:0] : '0;
  assign pop = evt_valid && evt_ready;
  assign full = cnt_q == (AW+1)'(FIFO_DEPTH);
  assign overflow = ovf_q;
  assign busy = state_q != IDLE;
  assign pio.address = addr_q;
  assign pio.chipselect = cs_q;
  assign pio.write_n = wn_q;
  assign pio.writedata = wd_q;
  always_comb begin
    state_d = state_q;
    edges_d = edges_q;
    level_d = level_q;
    hold_d = hold_q;
    addr_d = 2'd0;
    cs_d = 1'b0;
    wn_d = 1'b1;
    wd_d = '0;
    ovf_d = ovf_q;
    push = 1'b0;
`ifdef BUTTON_IRQ_SERVICE_CTRL_TIMESTAMP_EN
    ts_d = ts_q + 1'b1;
    tsc_d = tsc_q;
`endif
    case (state_q)
      INIT: begin
        state_d = IDLE;
        cs_d = 1'b1;
        wn_d = 1'b0;
        addr_d = 2'd2;
        wd_d = 32'(MASK_INIT);
      end
      IDLE: begin
        state_d = (enable && pio.irq) ? RD_EC : IDLE;
        cs_d = enable && pio.irq;
        addr_d = (enable && pio.irq) ? 2'd3 : 2'd0;
      end
      RD_EC: begin
        state_d = CAP_EC;
        cs_d = 1'b1;
      end
      CAP_EC: begin
        edges_d = pio.readdata[NUM_BTN-1:0];
        state_d = CLR;
        cs_d = 1'b1;
        wn_d = 1'b0;
        addr_d = 2'd3;
        wd_d = 32'(edges_d);
`ifdef BUTTON_IRQ_SERVICE_CTRL_TIMESTAMP_EN
        tsc_d = ts_q;
`endif
      end
      CLR: begin
        level_d = pio.readdata[NUM_BTN-1:0];
        state_d = PUSH;
      end
      PUSH: begin
        push = (edges_q != '0) && (!full || pop);
        ovf_d = ovf_q | ((edges_q != '0) && full && !pop);
        state_d = HOLDOFF_CYCLES == 0 ? IDLE : HOLD;
        hold_d = HW'(HOLDOFF_CYCLES - 1);
      end
      HOLD: begin
        hold_d = hold_q - 1'b1;
        state_d = hold_q == '0 ? IDLE : HOLD;
      end
      default: state_d = INIT;
    endcase
    wp_d = wp_q + AW'(push);
    rp_d = rp_q + AW'(pop);
    cnt_d = cnt_q + (AW+1)'(push) - (AW+1)'(pop);
  end
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= INIT;
      edges_q <= '0;
      level_q <= '0;
      hold_q <= '0;
      addr_q <= 2'd0;
      cs_q <= 1'b0;
      wn_q <= 1'b1;
      wd_q <= '0;
      ovf_q <= 1'b0;
      rp_q <= '0;
      wp_q <= '0;
      cnt_q <= '0;
`ifdef BUTTON_IRQ_SERVICE_CTRL_TIMESTAMP_EN
      ts_q <= '0;
      tsc_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      edges_q <= edges_d;
      level_q <= level_d;
      hold_q <= hold_d;
      addr_q <= addr_d;
      cs_q <= cs_d;
      wn_q <= wn_d;
      wd_q <= wd_d;
      ovf_q <= ovf_d;
      rp_q <= rp_d;
      wp_q <= wp_d;
      cnt_q <= cnt_d;
`ifdef BUTTON_IRQ_SERVICE_CTRL_TIMESTAMP_EN
      ts_q <= ts_d;
      tsc_q <= tsc_d;
`endif
    end
  end
  always_ff @(posedge clk) begin
    if (reset_n && push) mem_q[wp_q] <= push_data;
  end
endmodule

// File: tb/tb_button_irq_service_ctrl.sv
// tb_button_irq_service_ctrl: scoreboard bench with a behavioural button PIO
module tb_button_irq_service_ctrl;
  logic clk = 1'b0, reset_n = 1'b0, enable = 1'b0, evt_ready = 1'b0;
  logic evt_valid, overflow, busy;
  logic [1:0] evt_edges, evt_level;
`ifdef BUTTON_IRQ_SERVICE_CTRL_TIMESTAMP_EN
  logic [15:0] evt_ts;
`endif
  logic [1:0] ec = 2'b00, in_port = 2'b00, inj = 2'b00, mask = 2'b00;
  logic spur = 1'b0;
  logic [31:0] rd = 32'd0;
  logic [34:0] bus_exp [$];
  logic [3:0] evt_exp [$];
  int total = 0, bad = 0;
  logic [1:0] ed [5] = '{2'b01, 2'b10, 2'b11, 2'b01, 2'b10};
  logic [1:0] lv [5] = '{2'b00, 2'b01, 2'b10, 2'b11, 2'b00};
  button_irq_service_ctrl_if pio ();
  button_irq_service_ctrl #(.NUM_BTN(2), .FIFO_DEPTH(4), .HOLDOFF_CYCLES(8)) dut (
    .clk(clk), .reset_n(reset_n), .enable(enable), .pio(pio),
    .evt_valid(evt_valid), .evt_ready(evt_ready), .evt_edges(evt_edges), .evt_level(evt_level),
`ifdef BUTTON_IRQ_SERVICE_CTRL_TIMESTAMP_EN
    .evt_ts(evt_ts),
`endif
    .overflow(overflow), .busy(busy)
  );
  always #5 clk = ~clk;
  assign pio.readdata = rd;
  assign pio.irq = |(ec & mask) | spur;
  always @(posedge clk) begin
    if (pio.chipselect && pio.write_n)
      rd <= pio.address == 2'd3 ? 32'(ec) : pio.address == 2'd0 ? 32'(in_port) : pio.address == 2'd2 ? 32'(mask) : 32'd0;
    if (pio.chipselect && !pio.write_n && pio.address == 2'd2) mask <= pio.writedata[1:0];
    ec <= (ec & ~((pio.chipselect && !pio.write_n && pio.address == 2'd3) ? pio.writedata[1:0] : 2'b00)) | inj;
  end
  task automatic chk(input string n, input logic [34:0] a, input logic [34:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s got=%h want=%h", n, a, e);
    end
  endtask
  function automatic logic [34:0] bx(input logic w, input logic [1:0] a, input logic [31:0] d);
    return {w, a, d};
  endfunction
  always @(negedge clk) begin
    if (pio.chipselect) begin
      if (bus_exp.size() == 0) begin
        total++;
        bad++;
        $display("FAIL bus_unexpected got=%h want=none", {~pio.write_n, pio.address, pio.writedata});
      end else chk("bus", {~pio.write_n, pio.address, pio.writedata}, bus_exp.pop_front());
    end
    if (evt_valid && evt_ready) begin
      if (evt_exp.size() == 0) begin
        total++;
        bad++;
        $display("FAIL evt_unexpected got=%b%b want=none", evt_edges, evt_level);
      end else chk("evt", 35'({evt_edges, evt_level}), 35'(evt_exp.pop_front()));
    end
  end
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic expect_service(input logic [1:0] e, input logic [1:0] l, input bit p);
    bus_exp.push_back(bx(1'b0, 2'd3, 32'd0));
    bus_exp.push_back(bx(1'b0, 2'd0, 32'd0));
    bus_exp.push_back(bx(1'b1, 2'd3, 32'(e)));
    if (p) evt_exp.push_back({e, l});
  endtask
  task automatic wait_idle();
    int n = 0;
    while (busy && n < 100) begin
      tick(1);
      n++;
    end
    if (busy) begin
      total++;
      bad++;
      $display("FAIL idle_timeout busy=%b want=0", busy);
    end
  endtask
  task automatic pop_one();
    evt_ready = 1'b1;
    tick(1);
    evt_ready = 1'b0;
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end
  initial begin
    tick(3);
    chk("rst_bus", 35'({pio.chipselect, pio.write_n, pio.address, pio.writedata}), 35'({1'b0, 1'b1, 2'd0, 32'd0}));
    chk("rst_evt", 35'({evt_valid, evt_edges, evt_level}), 35'(0));
    chk("rst_busy", 35'(busy), 35'(1));
    chk("rst_ovf", 35'(overflow), 35'(0));
    bus_exp.push_back(bx(1'b1, 2'd2, 32'h3));
    reset_n = 1'b1;
    chk("init_busy", 35'(busy), 35'(1));
    tick(1);
    chk("init_write", 35'({pio.chipselect, pio.write_n, pio.address, pio.writedata}), 35'({1'b1, 1'b0, 2'd2, 32'h3}));
    chk("init_idle", 35'({busy, evt_valid, overflow}), 35'(0));
    tick(2);
    in_port = 2'b10;
    enable = 1'b1;
    expect_service(2'b01, 2'b10, 1'b1);
    inj = 2'b01;
    tick(1);
    inj = 2'b00;
    tick(4);
    chk("lat_before", 35'(evt_valid), 35'(0));
    tick(1);
    chk("lat_valid", 35'({evt_valid, evt_edges, evt_level}), 35'({1'b1, 2'b01, 2'b10}));
    chk("hold_start", 35'(busy), 35'(1));
    tick(7);
    chk("hold_last", 35'(busy), 35'(1));
    tick(1);
    chk("hold_done", 35'(busy), 35'(0));
    pop_one();
    chk("popped", 35'(evt_valid), 35'(0));
    for (int i = 0; i < 5; i++) begin
      in_port = lv[i];
      expect_service(ed[i], lv[i], i < 4);
      inj = ed[i];
      tick(1);
      inj = 2'b00;
      tick(2);
      wait_idle();
      if (i == 3) chk("ovf_before", 35'(overflow), 35'(0));
    end
    chk("ovf_after", 35'(overflow), 35'(1));
    chk("full_head", 35'({evt_valid, evt_edges, evt_level}), 35'({1'b1, 2'b01, 2'b00}));
    evt_ready = 1'b1;
    tick(4);
    evt_ready = 1'b0;
    chk("drained", 35'({evt_valid, evt_edges, evt_level}), 35'(0));
    expect_service(2'b00, 2'b00, 1'b0);
    spur = 1'b1;
    tick(1);
    spur = 1'b0;
    tick(2);
    wait_idle();
    chk("spur_nopush", 35'(evt_valid), 35'(0));
    chk("spur_ovf", 35'(overflow), 35'(1));
    enable = 1'b0;
    in_port = 2'b01;
    inj = 2'b10;
    tick(1);
    inj = 2'b00;
    tick(5);
    chk("gate_idle", 35'(busy), 35'(0));
    expect_service(2'b10, 2'b01, 1'b1);
    enable = 1'b1;
    tick(1);
    chk("gate_start", 35'(busy), 35'(1));
    tick(1);
    enable = 1'b0;
    wait_idle();
    chk("gate_done", 35'({evt_valid, evt_edges, evt_level}), 35'({1'b1, 2'b10, 2'b01}));
    pop_one();
    enable = 1'b1;
    expect_service(2'b11, 2'b01, 1'b1);
    inj = 2'b11;
    tick(1);
    inj = 2'b00;
    tick(2);
    wait_idle();
    chk("pre_rst_evt", 35'(evt_valid), 35'(1));
    in_port = 2'b10;
    expect_service(2'b01, 2'b10, 1'b0);
    inj = 2'b01;
    tick(1);
    inj = 2'b00;
    tick(3);
    chk("clr_state", 35'({busy, pio.chipselect, pio.write_n, pio.address}), 35'({1'b1, 1'b1, 1'b0, 2'd3}));
    reset_n = 1'b0;
    tick(1);
    evt_exp.delete();
    chk("mid_rst_bus", 35'(pio.chipselect), 35'(0));
    chk("mid_rst_fifo", 35'({evt_valid, overflow, busy}), 35'({1'b0, 1'b0, 1'b1}));
    bus_exp.push_back(bx(1'b1, 2'd2, 32'h3));
    reset_n = 1'b1;
    tick(1);
    chk("reinit_write", 35'({busy, pio.chipselect, pio.write_n, pio.address}), 35'({1'b0, 1'b1, 1'b0, 2'd2}));
    tick(3);
    chk("bus_q_empty", 35'(bus_exp.size()), 35'(0));
    chk("evt_q_empty", 35'(evt_exp.size()), 35'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
